// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: bus widths, load/store
// opcodes, funct3 codes, FSM state encoding and the alignment rule.
package mem_stage_pkg;

  localparam int InstBus    = 32;
  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int MemAddrBus = 32;

  localparam logic [6:0] INST_TYPE_L = 7'b0000011;
  localparam logic [6:0] INST_TYPE_S = 7'b0100011;

  localparam logic [2:0] INST_LB  = 3'b000;
  localparam logic [2:0] INST_LH  = 3'b001;
  localparam logic [2:0] INST_LW  = 3'b010;
  localparam logic [2:0] INST_LBU = 3'b100;
  localparam logic [2:0] INST_LHU = 3'b101;
  localparam logic [2:0] INST_SB  = 3'b000;
  localparam logic [2:0] INST_SH  = 3'b001;
  localparam logic [2:0] INST_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

  // funct3[1:0] gives the access size for loads and stores alike.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] idx);
    case (funct3[1:0])
      2'b01:   return idx == 2'd3;
      2'b10:   return idx != 2'd0;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane steering: store byte enables / replicated write data,
// and load byte/half extraction with sign or zero extension.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        waddr_index,
  input  logic [1:0]        raddr_index,
  input  logic [RegBus-1:0] store_data,
  input  logic [RegBus-1:0] load_word,
  output logic [3:0]        store_be,
  output logic [RegBus-1:0] store_wdata,
  output logic [RegBus-1:0] load_data
);

  logic [7:0]  load_byte;
  logic [15:0] load_half;

  always_comb begin
    store_be    = 4'b1111;
    store_wdata = store_data;
    case (funct3)
      INST_SB: begin
        store_be    = 4'b0001 << waddr_index;
        store_wdata = {4{store_data[7:0]}};
      end
      INST_SH: begin
        store_be    = waddr_index[1] ? 4'b1100 : 4'b0011;
        store_wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    load_byte = load_word[{raddr_index, 3'b000} +: 8];
    load_half = raddr_index[1] ? load_word[31:16] : load_word[15:0];
    load_data = load_word;
    case (funct3)
      INST_LB:  load_data = {{24{load_byte[7]}}, load_byte};
      INST_LBU: load_data = {24'h000000, load_byte};
      INST_LH:  load_data = {{16{load_half[15]}}, load_half};
      INST_LHU: load_data = {16'h0000, load_half};
      default:  ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: drives the req/gnt/rvalid data bus for loads and
// stores, stalls the pipeline while an access is outstanding, and forms write-back.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int BUS_TIMEOUT = 255,
  parameter int TMO_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [InstBus-1:0]    inst_i,
  input  logic [InstBus-1:0]    inst_addr_i,
  input  logic                  reg_we_i,
  input  logic [RegAddrBus-1:0] reg_waddr_i,
  input  logic [RegBus-1:0]     reg_wdata_i,
  input  logic [RegBus-1:0]     reg2_rdata_i,
  input  logic [MemAddrBus-1:0] op1_add_op2_res_i,
  input  logic [1:0]            mem_raddr_index_i,
  input  logic [1:0]            mem_waddr_index_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [MemAddrBus-1:0] mem_addr_o,
  output logic [RegBus-1:0]     mem_wdata_o,
  output logic [3:0]            mem_be_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [RegBus-1:0]     mem_rdata_i,
  output logic                  hold_req_o,
  output logic [InstBus-1:0]    inst_o,
  output logic [InstBus-1:0]    inst_addr_o,
  output logic                  reg_we_o,
  output logic [RegAddrBus-1:0] reg_waddr_o,
  output logic [RegBus-1:0]     reg_wdata_o,
  output logic                  misalign_o,
  output logic                  bus_err_o
);

  mem_state_e        state_reg, state_next;
  logic [TMO_W-1:0]  tmo_cnt_reg, tmo_cnt_next;
  logic [RegBus-1:0] rdata_reg;
  logic              bus_err_reg, bus_err_next;

  logic [2:0]        funct3;
  logic              is_load, is_store, is_mem, misaligned, issue, tmo_hit;
  logic [3:0]        store_be;
  logic [RegBus-1:0] store_wdata, load_data;

  assign funct3     = inst_i[14:12];
  assign is_load    = inst_i[6:0] == INST_TYPE_L;
  assign is_store   = inst_i[6:0] == INST_TYPE_S;
  assign is_mem     = is_load || is_store;
  assign misaligned = is_mem && is_misaligned(funct3, is_load ? mem_raddr_index_i : mem_waddr_index_i);
  assign issue      = (state_reg == ST_IDLE) && is_mem && !misaligned;
  // The cycle that enters REQ/WAIT counts as the first cycle of the budget.
  assign tmo_hit    = (tmo_cnt_reg + TMO_W'(1)) == TMO_W'(BUS_TIMEOUT);

  mem_align u_align (
    .funct3      (funct3),
    .waddr_index (mem_waddr_index_i),
    .raddr_index (mem_raddr_index_i),
    .store_data  (reg2_rdata_i),
    .load_word   (rdata_reg),
    .store_be    (store_be),
    .store_wdata (store_wdata),
    .load_data   (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      tmo_cnt_reg <= '0;
      rdata_reg   <= '0;
      bus_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      tmo_cnt_reg <= tmo_cnt_next;
      bus_err_reg <= bus_err_next;
      if (state_reg == ST_WAIT && mem_rvalid_i)
        rdata_reg <= mem_rdata_i;
    end
  end

  // Completing the handshake takes priority over a timeout in the same cycle.
  always_comb begin
    state_next   = state_reg;
    tmo_cnt_next = '0;
    bus_err_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (issue) begin
          tmo_cnt_next = TMO_W'(1);
          if (mem_gnt_i) state_next = is_store ? ST_DONE : ST_WAIT;
          else           state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_gnt_i) begin
          state_next   = is_store ? ST_DONE : ST_WAIT;
          tmo_cnt_next = TMO_W'(1);
        end else if (tmo_hit) begin
          state_next   = ST_DONE;
          bus_err_next = 1'b1;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
        end
      end
      ST_WAIT: begin
        if (mem_rvalid_i) begin
          state_next = ST_DONE;
        end else if (tmo_hit) begin
          state_next   = ST_DONE;
          bus_err_next = 1'b1;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req_o   = !rst && (issue || state_reg == ST_REQ);
    hold_req_o  = !rst && (issue || state_reg == ST_REQ || state_reg == ST_WAIT);
    mem_we_o    = mem_req_o && is_store;
    mem_be_o    = mem_req_o ? (is_store ? store_be : 4'b1111) : 4'b0000;
    mem_addr_o  = op1_add_op2_res_i & ~MemAddrBus'(3);
    mem_wdata_o = store_wdata;
    misalign_o  = !rst && state_reg == ST_IDLE && misaligned;
    bus_err_o   = bus_err_reg;
    inst_o      = inst_i;
    inst_addr_o = inst_addr_i;
    reg_waddr_o = reg_waddr_i;
    reg_wdata_o = (state_reg == ST_DONE && is_load) ? load_data : reg_wdata_i;
    reg_we_o    = is_mem ? (reg_we_i && is_load && state_reg == ST_DONE && !bus_err_reg)
                         : reg_we_i;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stores, loads with delayed handshakes,
// misalignment, bus timeout and reset during an outstanding load.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst, inst_addr, reg_wdata, reg2_rdata, op1;
  logic        reg_we;
  logic [4:0]  reg_waddr;
  logic [1:0]  raddr_idx, waddr_idx;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid, hold_req;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic [31:0] inst_o, inst_addr_o, reg_wdata_o;
  logic        reg_we_o, misalign, bus_err;
  logic [4:0]  reg_waddr_o;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] ADD = 32'h002081B3;

  mem_stage #(.BUS_TIMEOUT(4), .TMO_W(8)) dut (
    .clk(clk), .rst(rst),
    .inst_i(inst), .inst_addr_i(inst_addr),
    .reg_we_i(reg_we), .reg_waddr_i(reg_waddr), .reg_wdata_i(reg_wdata),
    .reg2_rdata_i(reg2_rdata), .op1_add_op2_res_i(op1),
    .mem_raddr_index_i(raddr_idx), .mem_waddr_index_i(waddr_idx),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .hold_req_o(hold_req),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o),
    .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
    .misalign_o(misalign), .bus_err_o(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [31:0] ins, input logic [31:0] addr,
                        input logic [31:0] rs2, input logic we, input logic [31:0] wd);
    inst       = ins;
    inst_addr  = 32'h0000_1000;
    op1        = addr;
    raddr_idx  = addr[1:0];
    waddr_idx  = addr[1:0];
    reg2_rdata = rs2;
    reg_we     = we;
    reg_waddr  = ins[11:7];
    reg_wdata  = wd;
  endtask

  function automatic logic [31:0] mk_load(input logic [2:0] f3, input logic [4:0] rd);
    return {12'h000, 5'd1, f3, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] mk_store(input logic [2:0] f3);
    return {7'h00, 5'd2, 5'd1, f3, 5'h00, 7'b0100011};
  endfunction

  initial begin
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    set_op(NOP, 32'h0, 32'h0, 1'b0, 32'h0);
    #3;
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_be", {28'b0, mem_be}, 32'd0);
    chk("rst_hold", {31'b0, hold_req}, 32'd0);
    chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
    chk("rst_inst_pass", inst_o, NOP);
    tick(); tick();
    rst = 1'b0;

    // SW 0xDEADBEEF to 0x100, granted immediately
    tick();
    set_op(mk_store(3'b010), 32'h100, 32'hDEADBEEF, 1'b1, 32'h0);
    mem_gnt = 1'b1; #1;
    chk("sw_req", {31'b0, mem_req}, 32'd1);
    chk("sw_we", {31'b0, mem_we}, 32'd1);
    chk("sw_hold", {31'b0, hold_req}, 32'd1);
    chk("sw_addr", mem_addr, 32'h100);
    chk("sw_be", {28'b0, mem_be}, 32'hF);
    chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
    tick(); mem_gnt = 1'b0; #1;
    chk("sw_done_hold", {31'b0, hold_req}, 32'd0);
    chk("sw_done_req", {31'b0, mem_req}, 32'd0);
    chk("sw_done_we", {31'b0, reg_we_o}, 32'd0);

    // LB from 0x203, grant in cycle 2, rvalid in cycle 3, DONE in cycle 4
    tick();
    set_op(mk_load(3'b000, 5'd5), 32'h203, 32'h0, 1'b1, 32'h12345678); #1;
    chk("lb_c0_req", {31'b0, mem_req}, 32'd1);
    chk("lb_c0_hold", {31'b0, hold_req}, 32'd1);
    chk("lb_addr", mem_addr, 32'h200);
    chk("lb_c0_we", {31'b0, mem_we}, 32'd0);
    tick(); #1;
    chk("lb_c1_req", {31'b0, mem_req}, 32'd1);
    chk("lb_c1_hold", {31'b0, hold_req}, 32'd1);
    tick(); mem_gnt = 1'b1; #1;
    chk("lb_c2_req", {31'b0, mem_req}, 32'd1);
    chk("lb_c2_hold", {31'b0, hold_req}, 32'd1);
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h80FF7F01; #1;
    chk("lb_c3_req", {31'b0, mem_req}, 32'd0);
    chk("lb_c3_hold", {31'b0, hold_req}, 32'd1);
    chk("lb_c3_regwe", {31'b0, reg_we_o}, 32'd0);
    tick(); mem_rvalid = 1'b0; mem_rdata = 32'h0; #1;
    chk("lb_done_hold", {31'b0, hold_req}, 32'd0);
    chk("lb_done_wdata", reg_wdata_o, 32'hFFFFFF80);
    chk("lb_done_we", {31'b0, reg_we_o}, 32'd1);
    chk("lb_done_waddr", {27'b0, reg_waddr_o}, 32'd5);

    // LHU from 0x202, granted at once, rvalid next cycle
    tick();
    set_op(mk_load(3'b101, 5'd6), 32'h202, 32'h0, 1'b1, 32'h0);
    mem_gnt = 1'b1; #1;
    chk("lhu_req", {31'b0, mem_req}, 32'd1);
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h8001ABCD; #1;
    chk("lhu_wait_hold", {31'b0, hold_req}, 32'd1);
    tick(); mem_rvalid = 1'b0; #1;
    chk("lhu_wdata", reg_wdata_o, 32'h00008001);
    chk("lhu_we", {31'b0, reg_we_o}, 32'd1);

    // SH rs2 low half 0x1234 at index 2
    tick();
    set_op(mk_store(3'b001), 32'h306, 32'hCAFE1234, 1'b0, 32'h0);
    mem_gnt = 1'b1; #1;
    chk("sh_be", {28'b0, mem_be}, 32'hC);
    chk("sh_wdata", mem_wdata, 32'h12341234);
    chk("sh_addr", mem_addr, 32'h304);
    tick(); mem_gnt = 1'b0; #1;
    chk("sh_done_hold", {31'b0, hold_req}, 32'd0);

    // SB 0xA5 at index 1
    tick();
    set_op(mk_store(3'b000), 32'h401, 32'h000000A5, 1'b0, 32'h0);
    mem_gnt = 1'b1; #1;
    chk("sb_be", {28'b0, mem_be}, 32'h2);
    chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
    tick(); mem_gnt = 1'b0;

    // LW from 0x101 is misaligned: no bus access, no stall
    tick();
    set_op(mk_load(3'b010, 5'd7), 32'h101, 32'h0, 1'b1, 32'h0); #1;
    chk("mis_flag", {31'b0, misalign}, 32'd1);
    chk("mis_req", {31'b0, mem_req}, 32'd0);
    chk("mis_hold", {31'b0, hold_req}, 32'd0);
    chk("mis_regwe", {31'b0, reg_we_o}, 32'd0);
    tick();
    set_op(NOP, 32'h0, 32'h0, 1'b0, 32'h0); #1;
    chk("mis_clear", {31'b0, misalign}, 32'd0);

    // LW with grant never given: bus error in cycle 4
    tick();
    set_op(mk_load(3'b010, 5'd8), 32'h500, 32'h0, 1'b1, 32'h0); #1;
    chk("tmo_c0_req", {31'b0, mem_req}, 32'd1);
    for (int c = 1; c <= 3; c++) begin
      tick(); #1;
      chk($sformatf("tmo_c%0d_req", c), {31'b0, mem_req}, 32'd1);
      chk($sformatf("tmo_c%0d_err", c), {31'b0, bus_err}, 32'd0);
    end
    tick(); #1;
    chk("tmo_c4_err", {31'b0, bus_err}, 32'd1);
    chk("tmo_c4_req", {31'b0, mem_req}, 32'd0);
    chk("tmo_c4_hold", {31'b0, hold_req}, 32'd0);
    chk("tmo_c4_regwe", {31'b0, reg_we_o}, 32'd0);
    tick();
    set_op(mk_store(3'b010), 32'h600, 32'h1, 1'b0, 32'h0);
    mem_gnt = 1'b1; #1;
    chk("tmo_c5_err", {31'b0, bus_err}, 32'd0);
    chk("tmo_c5_idle_req", {31'b0, mem_req}, 32'd1);
    tick(); mem_gnt = 1'b0; #1;
    chk("tmo_c6_hold", {31'b0, hold_req}, 32'd0);

    // Reset while waiting for rvalid
    tick();
    set_op(mk_load(3'b010, 5'd9), 32'h700, 32'h0, 1'b1, 32'h0);
    mem_gnt = 1'b1; #1;
    chk("rw_req", {31'b0, mem_req}, 32'd1);
    tick(); mem_gnt = 1'b0; #1;
    chk("rw_wait_hold", {31'b0, hold_req}, 32'd1);
    rst = 1'b1;
    set_op(NOP, 32'h0, 32'h0, 1'b0, 32'h0); #1;
    chk("rw_rst_hold", {31'b0, hold_req}, 32'd0);
    chk("rw_rst_req", {31'b0, mem_req}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    set_op(ADD, 32'h0, 32'h0, 1'b1, 32'h00000055);
    mem_rvalid = 1'b1; mem_rdata = 32'h00000BAD; #1;
    chk("add_wdata", reg_wdata_o, 32'h00000055);
    chk("add_we", {31'b0, reg_we_o}, 32'd1);
    chk("add_inst", inst_o, ADD);
    chk("add_hold", {31'b0, hold_req}, 32'd0);
    chk("add_req", {31'b0, mem_req}, 32'd0);
    tick(); mem_rvalid = 1'b0; #1;
    chk("add_still_idle", {31'b0, hold_req}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
